// File: rtl/it_run_trace_ctrl.sv
// Run/step controller with clock-enable gating and a {PC, inst, periph} trace FIFO.
// Optional TRACE_WRAP_EN: a full FIFO overwrites its oldest entry instead of dropping the new one.
module it_run_trace_ctrl #(
    parameter int PC_W     = 16,
    parameter int INST_W   = 32,
    parameter int PERIPH_W = 16,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      step,
    input  logic                      halt,
    input  logic [CNT_W-1:0]          run_cycles,
    input  logic [PC_W-1:0]           pc_in,
    input  logic [INST_W-1:0]         inst_in,
    input  logic [PERIPH_W-1:0]       periph_in,
    output logic                      core_ce,
    output logic                      busy,
    output logic                      done,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [PC_W-1:0]           rd_pc,
    output logic [INST_W-1:0]         rd_inst,
    output logic [PERIPH_W-1:0]       rd_periph,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = PC_W + INST_W + PERIPH_W;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ce_q, ce_d;
    logic              clr_ovf;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wp_q, rp_q;
    logic [LW-1:0]     lvl_q, lvl_d;
    logic              ovf_q;
    logic              rv_q;
    logic [EW-1:0]     rd_q;

    logic              wr, rd, lose, do_wr, adv_rp;

    // Next-state logic: accept start/step only when not busy; start wins over step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_d    = 1'b0;
        clr_ovf = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr_ovf = 1'b1;
                    if (run_cycles != '0) begin
                        state_d = S_RUN;
                        cnt_d   = run_cycles;
                        ce_d    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (step) begin
                    clr_ovf = 1'b1;
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (halt || cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    ce_d = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, counter and registered clock-enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ce_q    <= ce_d;
        end
    end

    assign wr   = ce_q;
    assign full = (lvl_q == DEPTH_L);
    assign rd   = rd_en && (lvl_q != '0);
    assign lose = wr && full && !rd;

`ifdef TRACE_WRAP_EN
    assign do_wr  = wr;
    assign adv_rp = rd || lose;
`else
    assign do_wr  = wr && !lose;
    assign adv_rp = rd;
`endif

    // Level bookkeeping: an overwrite counts as one push and one pop
    always_comb begin
        lvl_d = lvl_q;
        if (do_wr && !adv_rp) begin
            lvl_d = lvl_q + 1'b1;
        end else if (!do_wr && adv_rp) begin
            lvl_d = lvl_q - 1'b1;
        end
    end

    // Trace storage, written on each enabled core cycle
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wp_q] <= {pc_in, inst_in, periph_in};
        end
    end

    // FIFO pointers, level, overflow flag and read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
            rv_q  <= 1'b0;
            rd_q  <= '0;
        end else begin
            if (do_wr) begin
                wp_q <= wp_q + 1'b1;
            end
            if (adv_rp) begin
                rp_q <= rp_q + 1'b1;
            end
            lvl_q <= lvl_d;
            if (clr_ovf) begin
                ovf_q <= 1'b0;
            end else if (lose) begin
                ovf_q <= 1'b1;
            end
            rv_q <= rd;
            if (rd) begin
                rd_q <= mem[rp_q];
            end
        end
    end

    assign core_ce   = ce_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_STEP);
    assign done      = (state_q == S_DONE);
    assign rd_valid  = rv_q;
    assign rd_pc     = rd_q[EW-1 -: PC_W];
    assign rd_inst   = rd_q[PERIPH_W +: INST_W];
    assign rd_periph = rd_q[PERIPH_W-1:0];
    assign level     = lvl_q;
    assign empty     = (lvl_q == '0);
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_it_run_trace_ctrl.sv
// Directed bench for it_run_trace_ctrl.
// Core model: PC advances by one after every enabled cycle.
module tb_it_run_trace_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, step, halt, rd_en;
    logic [15:0] run_cycles;
    logic [15:0] pc_in;
    logic [31:0] inst_in;
    logic [15:0] periph_in;
    logic        core_ce, busy, done, rd_valid;
    logic [15:0] rd_pc;
    logic [31:0] rd_inst;
    logic [15:0] rd_periph;
    logic [4:0]  level;
    logic        empty, full, overflow;

    int n_chk = 0;
    int n_ok  = 0;
    int ce_cnt;
    int budget;

    it_run_trace_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step),
        .halt(halt), .run_cycles(run_cycles), .pc_in(pc_in),
        .inst_in(inst_in), .periph_in(periph_in),
        .core_ce(core_ce), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_pc(rd_pc),
        .rd_inst(rd_inst), .rd_periph(rd_periph), .level(level),
        .empty(empty), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic set_pc(input logic [15:0] v);
        pc_in     = v;
        inst_in   = {16'hA5A5, v};
        periph_in = ~v;
    endtask

    task automatic tick();
        logic ce_prev;
        ce_prev = core_ce;
        @(posedge clk);
        #1;
        if (ce_prev) begin
            ce_cnt++;
            set_pc(pc_in + 16'd1);
        end
    endtask

    task automatic wait_done();
        budget = 0;
        while (!done && budget < 200) begin
            tick();
            budget++;
        end
    endtask

    task automatic pop(input string tag, input logic [15:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_vld"}, rd_valid, 1);
        check({tag, "_pc"}, rd_pc, exp);
    endtask

    task automatic run(input logic [15:0] n);
        set_pc(16'd0);
        ce_cnt     = 0;
        run_cycles = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 0; step = 0; halt = 0; rd_en = 0;
        run_cycles = '0;
        set_pc(16'd0);
        ce_cnt = 0;
        #12;
        check("rst_ce", core_ce, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rv", rd_valid, 0);
        rst_n = 1'b1;
        tick();

        // 1: five-cycle run
        run(16'd5);
        check("t1_ce0", core_ce, 1);
        check("t1_busy", busy, 1);
        wait_done();
        check("t1_done", done, 1);
        check("t1_cecnt", ce_cnt, 5);
        check("t1_ce_off", core_ce, 0);
        check("t1_level", level, 5);
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_p0_vld", rd_valid, 1);
        check("t1_p0_pc", rd_pc, 0);
        check("t1_p0_inst", rd_inst, 32'hA5A50000);
        check("t1_p0_per", rd_periph, 16'hFFFF);
        for (int i = 1; i < 5; i++) pop("t1_pop", 16'(i));
        check("t1_empty", empty, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t1_pop_empty", rd_valid, 0);
        check("t1_lvl_empty", level, 0);

        // 2: zero-length run
        run(16'd0);
        check("t2_ce", core_ce, 0);
        check("t2_done", done, 1);
        tick();
        check("t2_done_end", done, 0);
        check("t2_cecnt", ce_cnt, 0);
        check("t2_empty", empty, 1);

        // 3: halt during third enabled cycle
        run(16'd100);
        budget = 0;
        while (ce_cnt < 2 && budget < 50) begin
            tick();
            budget++;
        end
        check("t3_ce3", core_ce, 1);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("t3_done", done, 1);
        check("t3_ce_off", core_ce, 0);
        check("t3_cecnt", ce_cnt, 3);
        check("t3_level", level, 3);
        tick();
        for (int i = 0; i < 3; i++) pop("t3_pop", 16'(i));
        check("t3_empty", empty, 1);

        // 4: overrun a 16-deep FIFO with 20 entries
        run(16'd20);
        wait_done();
        check("t4_done", done, 1);
        check("t4_cecnt", ce_cnt, 20);
        check("t4_full", full, 1);
        check("t4_ovf", overflow, 1);
        check("t4_level", level, 16);
        tick();
        for (int i = 0; i < 16; i++) begin
`ifdef TRACE_WRAP_EN
            pop("t4_pop", 16'(i + 4));
`else
            pop("t4_pop", 16'(i));
`endif
        end
        check("t4_empty", empty, 1);

        // 5: full FIFO, step with simultaneous pop
        run(16'd16);
        check("t5_ovf_clr", overflow, 0);
        wait_done();
        check("t5_full", full, 1);
        check("t5_ovf0", overflow, 0);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t5_step_ce", core_ce, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t5_vld", rd_valid, 1);
        check("t5_oldest", rd_pc, 0);
        check("t5_level", level, 16);
        check("t5_ovf", overflow, 0);
        check("t5_done", done, 1);
        for (int i = 1; i < 17; i++) pop("t5_pop", 16'(i));
        check("t5_empty", empty, 1);

        // 6: asynchronous reset in the middle of a run
        run(16'd100);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ce", core_ce, 0);
        check("t6_busy", busy, 0);
        check("t6_empty", empty, 1);
        check("t6_ovf", overflow, 0);
        #2;
        rst_n = 1'b1;
        tick();
        set_pc(16'h0042);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t6_step_ce", core_ce, 1);
        check("t6_step_busy", busy, 1);
        tick();
        check("t6_step_done", done, 1);
        check("t6_step_lvl", level, 1);
        pop("t6_pop", 16'h0042);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule
